vec_elem_seq: RTL and testbench
===============================

Name: vec_elem_seq

Overview:
- Element-beat sequencer between the vector configuration unit and the lane datapath.
- On each accepted vector instruction, latches the current AVL and SEW and splits the vector into DATA_WIDTH-wide beats.
- Each beat carries a start element index and a byte-enable mask; beats leave through a valid/ready handshake.
- Holds off configuration updates while a sequence is in flight and reports completion or an illegal configuration.

Parameters:
- VLEN, 16384, vector register length in bits.
- DATA_WIDTH, 64, datapath beat width in bits; power of two, at least 64.
- VLMAX, VLEN>>3, maximum element count.
- VLEN_B_BITS, $clog2(VLMAX), element index width.
- ENABLE_64_BIT, 1, when 0, SEW=64 (sew=2'b11) is illegal.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- cfg_avl, input, VLEN_B_BITS+1, current application vector length in elements; VLMAX is representable.
- cfg_sew, input, 2, element width code: 0=8b, 1=16b, 2=32b, 3=64b.
- cfg_vill, input, 1, current vtype is illegal.
- cfg_stall, output, 1, high blocks configuration-unit updates.
- req_valid, input, 1, instruction issue request.
- req_ready, output, 1, sequencer can accept a request.
- out_valid, output, 1, beat valid.
- out_ready, input, 1, datapath accepts beat.
- out_idx, output, VLEN_B_BITS, element index of the first element in the beat.
- out_be, output, DATA_WIDTH/8, byte enables for the beat.
- out_last, output, 1, final beat of the sequence.
- done, output, 1, one-cycle pulse when a sequence completes.
- err, output, 1, one-cycle pulse when a request is rejected.
- busy, output, 1, state is ISSUE.

Behaviour:
- Clock and reset: one clock domain. Asynchronous active-high reset (rst) sets state=IDLE and clears out_valid, out_last, done, err, busy, out_idx and out_be to 0.
- States: IDLE and ISSUE.
- req_ready = (state==IDLE). cfg_stall = (state!=IDLE). Both are combinational from state.
- Acceptance: a request is accepted when req_valid & req_ready at the cycle-N edge. At that edge, cfg_avl is latched as rem, cfg_sew as sew_q, and idx is set to 0. Later cfg changes have no effect on the running sequence.
- Accept-time decisions, evaluated at the cycle-N edge:
  - If cfg_vill, or cfg_sew==3 with ENABLE_64_BIT=0: err=1 during cycle N+1; stay IDLE; no beats.
  - Else if cfg_avl==0: done=1 during cycle N+1; stay IDLE; no beats.
  - Otherwise go to ISSUE. The first beat is valid in cycle N+1.
- Beat computation (registered outputs):
  - EPB = (DATA_WIDTH/8)>>sew_q elements per beat.
  - out_idx = idx.
  - If rem >= EPB: out_be = all ones.
  - If rem < EPB: out_be = (1<<(rem<<sew_q))-1.
  - out_last = (rem <= EPB).
- Beat handshake (out_valid & out_ready):
  - Not last beat: idx += EPB, rem -= EPB, and the next beat's outputs update the following cycle.
  - Last beat: out_valid drops, state returns to IDLE, and done=1 for exactly one cycle, the cycle after the handshake.
- Stall: while out_valid & !out_ready, out_idx, out_be and out_last hold stable. out_valid never deasserts without a handshake.
- Back-to-back: a new request can be accepted in the same cycle that done is high. Minimum one bubble cycle between sequences.
- Sequence length: the number of beats is ceil(avl/EPB). For avl=VLMAX and sew=0, that is VLMAX/(DATA_WIDTH/8) beats. idx never wraps because the largest idx is below VLMAX.
- Pulse exclusivity: done and err are never high in the same cycle.
- Reset mid-operation: the sequence is aborted immediately; no done pulse; all outputs return to reset values.

Test Plan:
- Byte elements, partial last beat: DATA_WIDTH=64, avl=20, sew=0, out_ready=1 → beats idx 0/8/16, be 0xFF/0xFF/0x0F, out_last only on the third beat; done one cycle after the third handshake; cfg_stall high from N+1 through the last handshake.
- 32-bit elements: avl=5, sew=2 → idx 0/2/4, be 0xFF/0xFF/0x0F, last on the third beat.
- Backpressure: avl=16, sew=1, out_ready toggles 1,0,0,1,1 → 4 beats idx 0/4/8/12; outputs held stable across low-ready cycles; exactly one done.
- Rejects and empty vector:
  - cfg_vill=1 → err pulse at N+1; no out_valid; req_ready stays high.
  - ENABLE_64_BIT=0 with sew=3 → err.
  - avl=0 → done at N+1 with no beats.
- Reset and back-to-back: assert rst during beat 2 of avl=64, sew=0 → outputs cleared asynchronously, no done. After release, a new request with avl=8 → single beat idx 0, be 0xFF, last=1. A second request issued in the done cycle is accepted.

Source files
------------

// File: rtl/vec_elem_seq.sv
// Element-beat sequencer: splits an accepted vector instruction into DATA_WIDTH-wide
// beats, each tagged with its first element index and a byte-enable mask.
module vec_elem_seq #(
    parameter int VLEN          = 16384,
    parameter int DATA_WIDTH    = 64,
    parameter int VLMAX         = VLEN >> 3,
    parameter int VLEN_B_BITS   = $clog2(VLMAX),
    parameter bit ENABLE_64_BIT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [VLEN_B_BITS:0]    cfg_avl,
    input  logic [1:0]              cfg_sew,
    input  logic                    cfg_vill,
    output logic                    cfg_stall,
    input  logic                    req_valid,
    output logic                    req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [VLEN_B_BITS-1:0]  out_idx,
    output logic [DATA_WIDTH/8-1:0] out_be,
    output logic                    out_last,
    output logic                    done,
    output logic                    err,
    output logic                    busy
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int AW = VLEN_B_BITS + 1;
    localparam int NW = AW + 3;

    typedef enum logic {IDLE, ISSUE} state_e;

    function automatic logic [AW-1:0] epb_of(input logic [1:0] sew);
        return AW'(BW >> sew);
    endfunction

    // A partial beat enables only the bytes covered by the remaining elements.
    function automatic logic [BW-1:0] be_of(input logic [AW-1:0] rem, input logic [1:0] sew);
        logic [NW-1:0] nbytes;
        logic [BW-1:0] be;
        nbytes = NW'(rem) << sew;
        be     = '0;
        if (rem >= epb_of(sew)) begin
            be = '1;
        end else begin
            for (int b = 0; b < BW; b++) begin
                be[b] = (NW'(b) < nbytes);
            end
        end
        return be;
    endfunction

    state_e                 state_q, state_d;
    logic [AW-1:0]          rem_q, rem_d;
    logic [1:0]             sew_q, sew_d;
    logic [VLEN_B_BITS-1:0] idx_q, idx_d;
    logic                   valid_q, valid_d;
    logic [VLEN_B_BITS-1:0] out_idx_q, out_idx_d;
    logic [BW-1:0]          out_be_q, out_be_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   load_beat;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        rem_d     = rem_q;
        sew_d     = sew_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        out_idx_d = out_idx_q;
        out_be_d  = out_be_q;
        last_d    = last_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        load_beat = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rem_d = cfg_avl;
                    sew_d = cfg_sew;
                    idx_d = '0;
                    if (cfg_vill || (cfg_sew == 2'b11 && !ENABLE_64_BIT)) begin
                        err_d = 1'b1;
                    end else if (cfg_avl == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ISSUE;
                        valid_d   = 1'b1;
                        load_beat = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (valid_q && out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        rem_d     = rem_q - epb_of(sew_q);
                        idx_d     = idx_q + VLEN_B_BITS'(epb_of(sew_q));
                        load_beat = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_beat) begin
            out_idx_d = idx_d;
            out_be_d  = be_of(rem_d, sew_d);
            last_d    = (rem_d <= epb_of(sew_d));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            sew_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            out_idx_q <= '0;
            out_be_q  <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            sew_q     <= sew_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            out_idx_q <= out_idx_d;
            out_be_q  <= out_be_d;
            last_q    <= last_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign cfg_stall = (state_q != IDLE);
    assign busy      = (state_q == ISSUE);
    assign out_valid = valid_q;
    assign out_idx   = out_idx_q;
    assign out_be    = out_be_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vec_elem_seq.sv
// Directed bench for vec_elem_seq (DATA_WIDTH=64); a second instance with
// 64-bit elements disabled covers the SEW=64 reject.
module tb_vec_elem_seq;

    localparam int VB = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic [VB:0]   cfg_avl;
    logic [1:0]    cfg_sew;
    logic          cfg_vill;
    logic          req_valid;
    logic          out_ready;
    logic          cfg_stall, req_ready, out_valid, out_last, done, err, busy;
    logic [VB-1:0] out_idx;
    logic [7:0]    out_be;
    logic          n_cfg_stall, n_req_ready, n_out_valid, n_out_last, n_done, n_err, n_busy;
    logic [VB-1:0] n_out_idx;
    logic [7:0]    n_out_be;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int done_ref;

    vec_elem_seq dut (
        .clk(clk), .rst(rst), .cfg_avl(cfg_avl), .cfg_sew(cfg_sew), .cfg_vill(cfg_vill),
        .cfg_stall(cfg_stall), .req_valid(req_valid), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_be(out_be),
        .out_last(out_last), .done(done), .err(err), .busy(busy)
    );

    vec_elem_seq #(.ENABLE_64_BIT(1'b0)) dut_n64 (
        .clk(clk), .rst(rst), .cfg_avl(cfg_avl), .cfg_sew(cfg_sew), .cfg_vill(cfg_vill),
        .cfg_stall(n_cfg_stall), .req_valid(req_valid), .req_ready(n_req_ready),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_idx(n_out_idx), .out_be(n_out_be),
        .out_last(n_out_last), .done(n_done), .err(n_err), .busy(n_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [VB-1:0] idx, input logic [7:0] be,
                        input logic last);
        chk({tag, " valid"}, 64'(out_valid), 64'd1);
        chk({tag, " idx"},   64'(out_idx),   64'(idx));
        chk({tag, " be"},    64'(out_be),    64'(be));
        chk({tag, " last"},  64'(out_last),  64'(last));
    endtask

    task automatic request(input logic [VB:0] avl, input logic [1:0] sew, input logic vill);
        cfg_avl   = avl;
        cfg_sew   = sew;
        cfg_vill  = vill;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_avl = '0; cfg_sew = '0; cfg_vill = 1'b0;
        req_valid = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst valid",  64'(out_valid), 64'd0);
        chk("rst idx",    64'(out_idx),   64'd0);
        chk("rst be",     64'(out_be),    64'd0);
        chk("rst last",   64'(out_last),  64'd0);
        chk("rst done",   64'(done),      64'd0);
        chk("rst err",    64'(err),       64'd0);
        chk("rst busy",   64'(busy),      64'd0);
        chk("rst ready",  64'(req_ready), 64'd1);
        chk("rst stall",  64'(cfg_stall), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Byte elements, partial last beat
        request(12'd20, 2'd0, 1'b0);
        beat("b8 beat0", 11'd0, 8'hFF, 1'b0);
        chk("b8 stall0", 64'(cfg_stall), 64'd1);
        chk("b8 ready0", 64'(req_ready), 64'd0);
        chk("b8 busy0",  64'(busy),      64'd1);
        step();
        beat("b8 beat1", 11'd8, 8'hFF, 1'b0);
        step();
        beat("b8 beat2", 11'd16, 8'h0F, 1'b1);
        chk("b8 stall2", 64'(cfg_stall), 64'd1);
        step();
        chk("b8 done",   64'(done),      64'd1);
        chk("b8 nvalid", 64'(out_valid), 64'd0);
        chk("b8 stall",  64'(cfg_stall), 64'd0);
        step();
        chk("b8 done off", 64'(done), 64'd0);

        // 32-bit elements
        request(12'd5, 2'd2, 1'b0);
        beat("w32 beat0", 11'd0, 8'hFF, 1'b0);
        step();
        beat("w32 beat1", 11'd2, 8'hFF, 1'b0);
        step();
        beat("w32 beat2", 11'd4, 8'h0F, 1'b1);
        step();
        chk("w32 done", 64'(done), 64'd1);
        step();

        // Backpressure on 16-bit elements
        done_ref = done_cnt;
        request(12'd16, 2'd1, 1'b0);
        beat("bp beat0", 11'd0, 8'hFF, 1'b0);
        step();
        beat("bp beat1", 11'd4, 8'hFF, 1'b0);
        out_ready = 1'b0;
        step();
        beat("bp hold1", 11'd4, 8'hFF, 1'b0);
        step();
        beat("bp hold2", 11'd4, 8'hFF, 1'b0);
        out_ready = 1'b1;
        step();
        beat("bp beat2", 11'd8, 8'hFF, 1'b0);
        step();
        beat("bp beat3", 11'd12, 8'hFF, 1'b1);
        step();
        chk("bp done", 64'(done), 64'd1);
        step();
        step();
        chk("bp done count", 64'(done_cnt - done_ref), 64'd1);

        // Illegal vtype
        request(12'd8, 2'd0, 1'b1);
        chk("vill err",   64'(err),       64'd1);
        chk("vill valid", 64'(out_valid), 64'd0);
        chk("vill ready", 64'(req_ready), 64'd1);
        chk("vill done",  64'(done),      64'd0);
        step();
        chk("vill err off", 64'(err), 64'd0);

        // SEW=64: legal on dut, rejected on dut_n64
        request(12'd3, 2'd3, 1'b0);
        chk("n64 err",   64'(n_err),       64'd1);
        chk("n64 valid", 64'(n_out_valid), 64'd0);
        chk("e64 err",   64'(err),         64'd0);
        beat("e64 beat0", 11'd0, 8'hFF, 1'b0);
        step();
        chk("n64 err off", 64'(n_err), 64'd0);
        beat("e64 beat1", 11'd1, 8'hFF, 1'b0);
        step();
        beat("e64 beat2", 11'd2, 8'hFF, 1'b1);
        step();
        chk("e64 done", 64'(done), 64'd1);
        step();

        // Empty vector
        request(12'd0, 2'd0, 1'b0);
        chk("avl0 done",  64'(done),      64'd1);
        chk("avl0 valid", 64'(out_valid), 64'd0);
        chk("avl0 err",   64'(err),       64'd0);
        step();
        chk("avl0 done off", 64'(done), 64'd0);

        // Reset during the second beat of a long sequence
        done_ref = done_cnt;
        request(12'd64, 2'd0, 1'b0);
        step();
        beat("rm beat1", 11'd8, 8'hFF, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rm valid", 64'(out_valid), 64'd0);
        chk("rm idx",   64'(out_idx),   64'd0);
        chk("rm be",    64'(out_be),    64'd0);
        chk("rm last",  64'(out_last),  64'd0);
        chk("rm busy",  64'(busy),      64'd0);
        chk("rm stall", 64'(cfg_stall), 64'd0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("rm no done", 64'(done_cnt - done_ref), 64'd0);

        // Single beat, then a request issued in the done cycle
        request(12'd8, 2'd0, 1'b0);
        beat("one beat", 11'd0, 8'hFF, 1'b1);
        step();
        chk("one done",  64'(done),      64'd1);
        chk("b2b ready", 64'(req_ready), 64'd1);
        request(12'd5, 2'd2, 1'b0);
        beat("b2b beat0", 11'd0, 8'hFF, 1'b0);
        step();
        beat("b2b beat1", 11'd2, 8'hFF, 1'b0);
        step();
        beat("b2b beat2", 11'd4, 8'h0F, 1'b1);
        step();
        chk("b2b done", 64'(done), 64'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
